// File: rtl/sensor_frame_packetizer.sv
// Packs a 16-bit sensor sample stream into 32-bit Avalon-ST packets:
// three header words followed by N_SAMPLES/2 data words per frame.
module sensor_frame_packetizer #(
    parameter int          N_SAMPLES = 320,
    parameter logic [31:0] SYNC_WORD = 32'h5A5AA5A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in_data,
    output logic        data_in_ready,
    input  logic        data_in_valid,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    output logic [31:0] data_out_data,
    input  logic        data_out_ready,
    output logic        data_out_valid,
    output logic [1:0]  data_out_empty,
    output logic        data_out_startofpacket,
    output logic        data_out_endofpacket,
    output logic [31:0] frame_count,
    output logic [2:0]  status_flags
);

    localparam int                N_WORDS     = N_SAMPLES / 2;
    localparam int                WC_W        = $clog2(N_WORDS + 1);
    localparam logic [WC_W-1:0]   LAST_WORD   = WC_W'(N_WORDS);
    localparam logic [WC_W-1:0]   WC_ONE      = WC_W'(1);
    localparam logic [15:0]       N_SAMPLES_W = 16'(N_SAMPLES);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        DATA,
        PAD,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic [15:0]      low_q, low_d;
    logic             low_full_q, low_full_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [31:0]      frame_count_q, frame_count_d;
    logic [2:0]       flags_q, flags_d;
    logic             eop_seen_q, eop_seen_d;
    logic             drain_done_q, drain_done_d;
    logic             init_done_q, init_done_d;

    logic             in_ready_raw;
    logic             in_xfer;
    logic             out_xfer;
    logic             out_free;
    logic [WC_W-1:0]  word_next;
    logic             last_next;

    assign out_xfer  = out_valid_q & data_out_ready;
    assign out_free  = !out_valid_q | data_out_ready;
    assign word_next = word_cnt_q + WC_ONE;
    assign last_next = (word_next == LAST_WORD);

    // Input side stays closed for the first cycle after reset release.
    always_comb begin
        in_ready_raw = 1'b0;
        case (state_q)
            IDLE:    in_ready_raw = 1'b1;
            DATA:    if (word_cnt_q != LAST_WORD) in_ready_raw = low_full_q ? out_free : 1'b1;
            DRAIN:   in_ready_raw = !drain_done_q;
            default: in_ready_raw = 1'b0;
        endcase
    end

    assign data_in_ready = init_done_q & in_ready_raw;
    assign in_xfer       = data_in_valid & data_in_ready;

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        low_d         = low_q;
        low_full_d    = low_full_q;
        word_cnt_d    = word_cnt_q;
        frame_count_d = frame_count_q;
        flags_d       = flags_q;
        eop_seen_d    = eop_seen_q;
        drain_done_d  = drain_done_q;
        init_done_d   = 1'b1;

        if (out_xfer) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            if (out_eop_q) frame_count_d = frame_count_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (in_xfer && data_in_startofpacket) begin
                    low_d        = data_in_data;
                    low_full_d   = 1'b1;
                    word_cnt_d   = '0;
                    eop_seen_d   = data_in_endofpacket;
                    drain_done_d = 1'b0;
                    out_data_d   = SYNC_WORD;
                    out_valid_d  = 1'b1;
                    out_sop_d    = 1'b1;
                    out_eop_d    = 1'b0;
                    state_d      = HDR0;
                end
            end

            HDR0: begin
                if (out_xfer) begin
                    out_data_d  = frame_count_q;
                    out_valid_d = 1'b1;
                    state_d     = HDR1;
                end
            end

            HDR1: begin
                if (out_xfer) begin
                    out_data_d  = {13'b0, flags_q, N_SAMPLES_W};
                    out_valid_d = 1'b1;
                    state_d     = HDR2;
                end
            end

            HDR2: begin
                if (out_xfer) begin
                    if (eop_seen_q) begin
                        flags_d[0] = 1'b1;
                        state_d    = PAD;
                    end else begin
                        state_d    = DATA;
                    end
                end
            end

            DATA: begin
                if (word_cnt_q == LAST_WORD) begin
                    if (out_xfer) state_d = IDLE;
                end else if (in_xfer) begin
                    if (data_in_startofpacket) flags_d[2] = 1'b1;
                    if (!low_full_q) begin
                        low_d      = data_in_data;
                        low_full_d = 1'b1;
                        if (data_in_endofpacket) begin
                            flags_d[0] = 1'b1;
                            state_d    = PAD;
                        end
                    end else begin
                        out_data_d  = {data_in_data, low_q};
                        out_valid_d = 1'b1;
                        out_sop_d   = 1'b0;
                        out_eop_d   = last_next;
                        low_d       = '0;
                        low_full_d  = 1'b0;
                        word_cnt_d  = word_next;
                        if (last_next && !data_in_endofpacket) begin
                            flags_d[1] = 1'b1;
                            state_d    = DRAIN;
                        end else if (!last_next && data_in_endofpacket) begin
                            flags_d[0] = 1'b1;
                            state_d    = PAD;
                        end
                    end
                end
            end

            // A pending odd sample goes out first, then zero words up to the EOP word.
            PAD: begin
                if (word_cnt_q == LAST_WORD) begin
                    if (out_xfer) state_d = IDLE;
                end else if (out_free) begin
                    out_data_d  = low_full_q ? {16'h0000, low_q} : 32'h0;
                    out_valid_d = 1'b1;
                    out_sop_d   = 1'b0;
                    out_eop_d   = last_next;
                    low_d       = '0;
                    low_full_d  = 1'b0;
                    word_cnt_d  = word_next;
                end
            end

            // The EOP word may still be stalled; IDLE is entered only with the output free.
            DRAIN: begin
                if (!drain_done_q) begin
                    if (in_xfer && data_in_endofpacket) begin
                        if (!out_valid_q || out_xfer) state_d = IDLE;
                        else drain_done_d = 1'b1;
                    end
                end else if (!out_valid_q || out_xfer) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop is cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            low_q         <= '0;
            low_full_q    <= 1'b0;
            word_cnt_q    <= '0;
            frame_count_q <= '0;
            flags_q       <= '0;
            eop_seen_q    <= 1'b0;
            drain_done_q  <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            low_q         <= low_d;
            low_full_q    <= low_full_d;
            word_cnt_q    <= word_cnt_d;
            frame_count_q <= frame_count_d;
            flags_q       <= flags_d;
            eop_seen_q    <= eop_seen_d;
            drain_done_q  <= drain_done_d;
            init_done_q   <= init_done_d;
        end
    end

    assign data_out_data          = out_data_q;
    assign data_out_valid         = out_valid_q;
    assign data_out_startofpacket = out_sop_q;
    assign data_out_endofpacket   = out_eop_q;
    assign data_out_empty         = 2'b00;
    assign frame_count            = frame_count_q;
    assign status_flags           = flags_q;

endmodule

// File: tb/tb_sensor_frame_packetizer.sv
// Scoreboard bench for sensor_frame_packetizer: each frame's expected packet is
// built from the driven samples and compared word by word as the DUT emits it.
module tb_sensor_frame_packetizer;

    localparam int          N_SAMPLES = 320;
    localparam int          N_WORDS   = N_SAMPLES / 2;
    localparam logic [31:0] SYNC_WORD = 32'h5A5AA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_in_data = '0;
    logic        data_in_ready;
    logic        data_in_valid = 1'b0;
    logic        data_in_startofpacket = 1'b0;
    logic        data_in_endofpacket = 1'b0;
    logic [31:0] data_out_data;
    logic        data_out_ready = 1'b1;
    logic        data_out_valid;
    logic [1:0]  data_out_empty;
    logic        data_out_startofpacket;
    logic        data_out_endofpacket;
    logic [31:0] frame_count;
    logic [2:0]  status_flags;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } word_t;

    word_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [31:0] exp_fc = '0;
    logic [2:0]  exp_flags = '0;
    logic        rand_ready = 1'b0;
    logic        hold_pending = 1'b0;
    word_t       held;

    always #5 clk = ~clk;

    sensor_frame_packetizer #(
        .N_SAMPLES (N_SAMPLES),
        .SYNC_WORD (SYNC_WORD)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .data_in_data           (data_in_data),
        .data_in_ready          (data_in_ready),
        .data_in_valid          (data_in_valid),
        .data_in_startofpacket  (data_in_startofpacket),
        .data_in_endofpacket    (data_in_endofpacket),
        .data_out_data          (data_out_data),
        .data_out_ready         (data_out_ready),
        .data_out_valid         (data_out_valid),
        .data_out_empty         (data_out_empty),
        .data_out_startofpacket (data_out_startofpacket),
        .data_out_endofpacket   (data_out_endofpacket),
        .frame_count            (frame_count),
        .status_flags           (status_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink: always ready, or a coin flip per cycle.
    always @(posedge clk) begin
        #1;
        data_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        word_t cur;
        word_t e;
        cur = '{sop: data_out_startofpacket, eop: data_out_endofpacket, data: data_out_data};
        if (!rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("stall_valid", 64'(data_out_valid), 64'd1);
                check("stall_hold", 64'(cur), 64'(held));
            end
            if (data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 64'(cur), 64'(e));
                end
                hold_pending = 1'b0;
            end else if (data_out_valid) begin
                hold_pending = 1'b1;
                held = cur;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    function automatic logic [15:0] samp(input int base, input int i);
        return 16'(base + i);
    endfunction

    // Expected packet for a frame of n samples (SOP on sample 0, EOP on sample n-1).
    task automatic push_expected(input int n, input int base, input int sop_idx);
        int used;
        logic [15:0] lo;
        logic [15:0] hi;
        used = (n < N_SAMPLES) ? n : N_SAMPLES;
        exp_q.push_back('{sop: 1'b1, eop: 1'b0, data: SYNC_WORD});
        exp_q.push_back('{sop: 1'b0, eop: 1'b0, data: exp_fc});
        exp_q.push_back('{sop: 1'b0, eop: 1'b0, data: {13'b0, exp_flags, 16'(N_SAMPLES)}});
        for (int w = 0; w < N_WORDS; w++) begin
            lo = (2 * w < used)     ? samp(base, 2 * w)     : 16'h0000;
            hi = (2 * w + 1 < used) ? samp(base, 2 * w + 1) : 16'h0000;
            exp_q.push_back('{sop: 1'b0, eop: (w == N_WORDS - 1), data: {hi, lo}});
        end
        exp_fc = exp_fc + 32'd1;
        if (n < N_SAMPLES) exp_flags[0] = 1'b1;
        if (n > N_SAMPLES) exp_flags[1] = 1'b1;
        if (sop_idx > 0 && sop_idx < used) exp_flags[2] = 1'b1;
    endtask

    // Drives one sample; entered and left at posedge+1.
    task automatic push_sample(input logic [15:0] d, input logic sop, input logic eop);
        int t;
        logic accepted;
        data_in_data          = d;
        data_in_startofpacket = sop;
        data_in_endofpacket   = eop;
        data_in_valid         = 1'b1;
        t = 0;
        accepted = 1'b0;
        while (!accepted && t < 3000) begin
            @(negedge clk);
            accepted = data_in_ready;
            t++;
        end
        if (!accepted) check("in_ready_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1;
        data_in_valid         = 1'b0;
        data_in_startofpacket = 1'b0;
        data_in_endofpacket   = 1'b0;
    endtask

    task automatic send_frame(input int n, input int base, input int sop_idx);
        push_expected(n, base, sop_idx);
        for (int i = 0; i < n; i++)
            push_sample(samp(base, i), (i == 0) || (i == sop_idx), (i == n - 1));
    endtask

    task automatic send_junk(input int n, input int base);
        for (int i = 0; i < n; i++)
            push_sample(samp(base, i), 1'b0, (i == n - 1));
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check({tag, "_frame_count"}, 64'(frame_count), 64'(exp_fc));
        check({tag, "_flags"}, 64'(status_flags), 64'(exp_flags));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(data_out_valid), 64'd0);
        check("rst_in_ready", 64'(data_in_ready), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_flags", 64'(status_flags), 64'd0);
        check("rst_out_data", 64'({data_out_startofpacket, data_out_endofpacket, data_out_data}), 64'd0);
        check("rst_empty", 64'(data_out_empty), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Samples without SOP in IDLE are dropped, then a nominal frame
        send_junk(3, 16'h7700);
        send_frame(N_SAMPLES, 0, -1);
        wait_idle("nominal");

        // Random sink backpressure over three frames
        rand_ready = 1'b1;
        send_frame(N_SAMPLES, 16'h1000, -1);
        send_frame(N_SAMPLES, 16'h2000, -1);
        send_frame(N_SAMPLES, 16'h3000, -1);
        wait_idle("backpressure");

        // Short frame ending on an odd sample count, then a nominal frame
        send_frame(101, 16'h4000, -1);
        wait_idle("short_odd");
        send_frame(N_SAMPLES, 16'h5000, -1);
        wait_idle("after_short");

        // Long frame: 4 extra samples discarded, junk before the next SOP
        send_frame(N_SAMPLES + 4, 16'h6000, -1);
        wait_idle("long");
        send_junk(2, 16'h6F00);
        send_frame(N_SAMPLES, 16'h7000, -1);
        wait_idle("after_long");

        // Even-length short frame, single-sample frame, mid-frame SOP
        send_frame(100, 16'h8000, -1);
        wait_idle("short_even");
        send_frame(1, 16'h9000, -1);
        wait_idle("short_one");
        send_frame(N_SAMPLES, 16'hA000, 10);
        wait_idle("mid_sop");
        rand_ready = 1'b0;

        // Reset in the middle of the data phase
        push_expected(N_SAMPLES, 16'hB000, -1);
        for (int i = 0; i < 60; i++)
            push_sample(samp(16'hB000, i), (i == 0), 1'b0);
        rst = 1'b0;
        exp_q.delete();
        exp_fc = '0;
        exp_flags = '0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(data_out_valid), 64'd0);
        check("midrst_in_ready", 64'(data_in_ready), 64'd0);
        check("midrst_frame_count", 64'(frame_count), 64'd0);
        check("midrst_flags", 64'(status_flags), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(N_SAMPLES, 16'hC000, -1);
        wait_idle("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
